// File: rtl/reg_writeback_seq.sv
// Write-back sequencer feeding the 8088 register file: one request in, one-hot
// WE/DATA out, with AX/CX/DX/BX word writes split into low then high byte.
module reg_writeback_seq #(
  parameter int DATA_W = 16,  // only 16 is supported
  parameter int NWE    = 12   // only 12 is supported
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_w,
  input  logic [2:0]        req_reg,
  input  logic [DATA_W-1:0] req_data,
  output logic [NWE-1:0]    WE,
  output logic [DATA_W-1:0] DATA,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, WR1, WR_HI} state_t;

  state_t              r_state;
  logic                r_split;
  logic [7:0]          r_hi_byte;
  logic [NWE-1:0]      r_hi_we;
  logic [NWE-1:0]      r_we;
  logic [DATA_W-1:0]   r_data;
  logic                r_done;

  logic                w_accept;
  logic                w_word_reg;
  logic                w_split;
  logic [3:0]          w_lo_idx;
  logic [3:0]          w_hi_idx;
  logic [NWE-1:0]      w_one;
  logic [NWE-1:0]      w_first_we;
  logic [NWE-1:0]      w_hi_we;
  logic [DATA_W-1:0]   w_first_data;

  assign req_ready = !RST && ((r_state == IDLE) || (r_state == WR1 && !r_split) ||
                              (r_state == WR_HI));
  assign w_accept  = req_valid && req_ready;

  assign w_word_reg = req_w &  req_reg[2];  // SP/BP/SI/DI: full 16-bit register
  assign w_split    = req_w & ~req_reg[2];  // AX/CX/DX/BX: two byte halves

  // Byte regs code c sit at WE[11-c]; 7-c gives both the high half of a split
  // word (AH..BH) and the single-cycle word registers (SP..DI).
  assign w_lo_idx = 4'd11 - {1'b0, req_reg};
  assign w_hi_idx = 4'd7  - {1'b0, req_reg};
  assign w_one    = {{(NWE-1){1'b0}}, 1'b1};

  assign w_first_we   = w_one << (w_word_reg ? w_hi_idx : w_lo_idx);
  assign w_hi_we      = w_one << w_hi_idx;
  assign w_first_data = w_word_reg ? req_data : {8'h00, req_data[7:0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_split   <= 1'b0;
      r_hi_byte <= 8'h00;
      r_hi_we   <= '0;
      r_we      <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_we    <= '0;
      r_done  <= 1'b0;
      r_state <= IDLE;
      if (w_accept) begin
        r_state   <= WR1;
        r_we      <= w_first_we;
        r_data    <= w_first_data;
        r_done    <= ~w_split;
        r_split   <= w_split;
        r_hi_byte <= req_data[DATA_W-1:8];
        r_hi_we   <= w_hi_we;
      end else if (r_state == WR1 && r_split) begin
        r_state <= WR_HI;
        r_we    <= r_hi_we;
        r_data  <= {8'h00, r_hi_byte};
        r_done  <= 1'b1;
        r_split <= 1'b0;
      end
      // DATA is left untouched when idle so the last written value stays visible
    end
  end

  assign WE   = r_we;
  assign DATA = r_data;
  assign busy = |r_we;
  assign done = r_done;

endmodule

// File: tb/tb_reg_writeback_seq.sv
// Bench for reg_writeback_seq: directed scenarios plus a random run checked
// against a behavioural model of the twelve 8088 registers.
module tb_reg_writeback_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_w = 1'b0;
  logic [2:0]  req_reg = 3'd0;
  logic [15:0] req_data = 16'h0;
  logic [11:0] WE;
  logic [15:0] DATA;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  reg_writeback_seq #(.DATA_W(16), .NWE(12)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_w(req_w), .req_reg(req_reg), .req_data(req_data),
    .WE(WE), .DATA(DATA), .busy(busy), .done(done)
  );

  // Bench-side register file: 8-bit regs at WE[11:4], 16-bit regs at WE[3:0].
  logic [15:0] rf [12];
  logic        rf_clr = 1'b0;
  always @(posedge CLK) begin
    for (int i = 0; i < 12; i++) begin
      if (rf_clr) rf[i] <= 16'h0;
      else if (WE[i]) rf[i] <= (i >= 4) ? {8'h00, DATA[7:0]} : DATA;
    end
  end

  task automatic drive(input logic w, input logic [2:0] r, input logic [15:0] d);
    req_valid = 1'b1; req_w = w; req_reg = r; req_data = d;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    if (WE !== 12'h0 || DATA !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b0) begin
      $display("FAIL reset_state: WE=%h DATA=%h busy=%b done=%b ready=%b, want all 0", WE, DATA, busy, done, req_ready);
    end else n_pass++;
    n_checks++;
    RST = 1'b0;
    @(negedge CLK);
    if (req_ready !== 1'b1) $display("FAIL reset_ready: ready=%b want 1", req_ready);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_byte();
    drive(1'b0, 3'b100, 16'h12AB);
    @(negedge CLK);
    req_valid = 1'b0;
    if (WE !== 12'h080 || DATA !== 16'h00AB || done !== 1'b1 || busy !== 1'b1)
      $display("FAIL byte_ah: WE=%h DATA=%h done=%b busy=%b, want 080 00AB 1 1", WE, DATA, done, busy);
    else n_pass++;
    n_checks++;
    @(negedge CLK);
    if (WE !== 12'h0 || done !== 1'b0 || busy !== 1'b0 || DATA !== 16'h00AB)
      $display("FAIL byte_idle: WE=%h done=%b busy=%b DATA=%h, want 0 0 0 00AB", WE, done, busy, DATA);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_word_single();
    drive(1'b1, 3'b110, 16'hBEEF);
    @(negedge CLK);
    req_valid = 1'b0;
    if (WE !== 12'h002 || DATA !== 16'hBEEF || done !== 1'b1)
      $display("FAIL word_si: WE=%h DATA=%h done=%b, want 002 BEEF 1", WE, DATA, done);
    else n_pass++;
    n_checks++;
    @(negedge CLK);
    if (WE !== 12'h0 || done !== 1'b0) $display("FAIL word_si_end: WE=%h done=%b, want 0 0", WE, done);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_split();
    drive(1'b1, 3'b000, 16'h1234);
    @(negedge CLK);
    if (WE !== 12'h800 || DATA !== 16'h0034 || done !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL split_lo: WE=%h DATA=%h done=%b ready=%b, want 800 0034 0 0", WE, DATA, done, req_ready);
    else n_pass++;
    n_checks++;
    req_valid = 1'b0;
    @(negedge CLK);
    if (WE !== 12'h080 || DATA !== 16'h0012 || done !== 1'b1 || req_ready !== 1'b1)
      $display("FAIL split_hi: WE=%h DATA=%h done=%b ready=%b, want 080 0012 1 1", WE, DATA, done, req_ready);
    else n_pass++;
    n_checks++;
    @(negedge CLK);
    if (WE !== 12'h0 || done !== 1'b0) $display("FAIL split_end: WE=%h done=%b, want 0 0", WE, done);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_back_to_back();
    logic        sw [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0]  sr [4] = '{3'b100, 3'b101, 3'b001, 3'b111};
    logic [15:0] sd [4] = '{16'h1111, 16'h2222, 16'h3355, 16'h4444};
    logic [11:0] ew [4] = '{12'h008, 12'h004, 12'h400, 12'h001};
    logic [15:0] ed [4] = '{16'h1111, 16'h2222, 16'h0055, 16'h4444};
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        if (WE !== ew[i-1] || DATA !== ed[i-1] || done !== 1'b1)
          $display("FAIL stream_%0d: WE=%h DATA=%h done=%b, want %h %h 1", i-1, WE, DATA, done, ew[i-1], ed[i-1]);
        else n_pass++;
        n_checks++;
      end
      if (i < 4) begin
        drive(sw[i], sr[i], sd[i]);
        if (req_ready !== 1'b1) $display("FAIL stream_ready_%0d: ready=%b want 1", i, req_ready);
        else n_pass++;
        n_checks++;
      end else req_valid = 1'b0;
      @(negedge CLK);
    end
    if (WE !== 12'h0) $display("FAIL stream_end: WE=%h want 0", WE);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    drive(1'b1, 3'b011, 16'hABCD);
    @(negedge CLK);
    req_valid = 1'b0;
    if (WE !== 12'h100 || DATA !== 16'h00CD || done !== 1'b0)
      $display("FAIL rstmid_lo: WE=%h DATA=%h done=%b, want 100 00CD 0", WE, DATA, done);
    else n_pass++;
    n_checks++;
    RST = 1'b1;
    @(negedge CLK);
    if (WE !== 12'h0 || DATA !== 16'h0 || done !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL rstmid_rst: WE=%h DATA=%h done=%b ready=%b, want 0 0 0 0", WE, DATA, done, req_ready);
    else n_pass++;
    n_checks++;
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (WE !== 12'h0 || done !== 1'b0) bad++;
    end
    if (bad != 0) $display("FAIL rstmid_after: %0d cycles with WE/done set, want 0", bad);
    else n_pass++;
    n_checks++;
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  r;
    logic [15:0] d;
  } req_t;

  task automatic test_random();
    logic [7:0]  mb [8];   // AL CL DL BL AH CH DH BH
    logic [15:0] mw [4];   // SP BP SI DI
    req_t        q [$];
    req_t        cur;
    logic        last_fire = 1'b0;
    logic        chk = 1'b0;
    int          rf_bad = 0, hot_bad = 0, n_done = 0;
    for (int i = 0; i < 8; i++) mb[i] = 8'h0;
    for (int i = 0; i < 4; i++) mw[i] = 16'h0;
    rf_clr = 1'b1;
    @(negedge CLK);
    rf_clr = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (chk) begin
        for (int c = 0; c < 8; c++) if (rf[11-c][7:0] !== mb[c]) rf_bad++;
        for (int k = 0; k < 4; k++) if (rf[3-k] !== mw[k]) rf_bad++;
        chk = 1'b0;
      end
      if (!$onehot0(WE) || busy !== (WE != 12'h0)) hot_bad++;
      if (done === 1'b1) begin
        if (q.size() == 0) rf_bad++;
        else begin
          cur = q.pop_front();
          if (!cur.w) mb[cur.r] = cur.d[7:0];
          else if (!cur.r[2]) begin
            mb[cur.r] = cur.d[7:0];
            mb[cur.r + 3'd4] = cur.d[15:8];
          end else mw[cur.r - 3'd4] = cur.d;
          n_done++;
          chk = 1'b1;
        end
      end
      if (!req_valid || last_fire) begin
        if (cyc < 1400 && $urandom_range(0, 3) != 0)
          drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
        else req_valid = 1'b0;
      end
      last_fire = req_valid && req_ready;
      if (last_fire) begin
        cur.w = req_w; cur.r = req_reg; cur.d = req_data;
        q.push_back(cur);
      end
      @(negedge CLK);
    end
    if (rf_bad != 0) $display("FAIL rand_regfile: %0d register mismatches, want 0", rf_bad);
    else n_pass++;
    n_checks++;
    if (hot_bad != 0) $display("FAIL rand_onehot: %0d cycles bad WE/busy, want 0", hot_bad);
    else n_pass++;
    n_checks++;
    if (q.size() != 0 || n_done < 100)
      $display("FAIL rand_drain: pending=%0d completed=%0d, want 0 and >=100", q.size(), n_done);
    else n_pass++;
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_byte();
    test_word_single();
    test_split();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
